// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_e : fetch FSM states (idle after reset, fetching, holding a
//                   buffered response, discarding a stale response).
//   NOP           : instruction word used to flush IF/ID.
//   OP_MSB/OP_LSB : opcode field bounds of a MIPS instruction.
//   JUMP_IDX_*    : bounds of the 26-bit J-type target index.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFetch   = 2'd1,
    StHold    = 2'd2,
    StDiscard = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 26;

  localparam int unsigned JUMP_IDX_MSB = 25;
  localparam int unsigned JUMP_IDX_LSB = 0;

  // Opcode field of an instruction word, as seen by the main decoder.
  function automatic logic [5:0] opcode(input logic [31:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/fetch_skid_reg.sv
// fetch_skid_reg: one-entry buffer holding a fetched instruction and its PC+4
// when decode is stalled at the moment the memory response arrives.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   load_i              : capture instr_i / pc_plus4_i and mark full
//   clear_i             : empty the buffer (wins over load_i)
//   instr_i, pc_plus4_i : entry to capture
//   instr_o, pc_plus4_o : buffered entry
//   full_o              : buffer holds a valid entry
module fetch_skid_reg #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [Width-1:0] instr_i,
  input  logic [Width-1:0] pc_plus4_i,
  output logic [Width-1:0] instr_o,
  output logic [Width-1:0] pc_plus4_o,
  output logic             full_o
);

  logic [Width-1:0] instr_q, instr_d;
  logic [Width-1:0] pc_plus4_q, pc_plus4_d;
  logic             full_q, full_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    full_d     = full_q;
    if (clear_i) begin
      instr_d    = '0;
      pc_plus4_d = '0;
      full_d     = 1'b0;
    end else if (load_i) begin
      instr_d    = instr_i;
      pc_plus4_d = pc_plus4_i;
      full_d     = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q    <= '0;
      pc_plus4_q <= '0;
      full_q     <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      full_q     <= full_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign full_o     = full_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage plus IF/ID pipeline register.
// Holds the PC, issues requests to instruction memory over a ready
// handshake, applies branch/jump redirects and presents the fetched
// instruction with its PC+4 to decode.
//   clk, rst_n                : clock, asynchronous active-low reset
//   imemAddr, imemReq         : fetch request (address held while pending)
//   imemRdata, imemReady      : response data and completion strobe
//   stall                     : hazard unit holds IF/ID
//   branchTaken, branchTarget : EX-stage taken branch and its target
//   jumpId                    : decoder jump flag for the IF/ID instruction
//   instrId, pcPlus4Id        : IF/ID instruction and PC+4
//   validId                   : IF/ID holds a live instruction
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] imemAddr,
  output logic             imemReq,
  input  logic [WIDTH-1:0] imemRdata,
  input  logic             imemReady,
  input  logic             stall,
  input  logic             branchTaken,
  input  logic [WIDTH-1:0] branchTarget,
  input  logic             jumpId,
  output logic [WIDTH-1:0] instrId,
  output logic [WIDTH-1:0] pcPlus4Id,
  output logic             validId
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic             req_q, req_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pc4_id_q, pc4_id_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] jump_tgt;
  logic             jump_take;
  logic             redirect;
  logic [WIDTH-1:0] redirect_tgt;

  logic             skid_load, skid_clear, skid_full;
  logic [WIDTH-1:0] skid_instr, skid_pc4;

  assign pc_plus4 = pc_q + WIDTH'(4);
  assign jump_tgt = {pc4_id_q[WIDTH-1:28], instr_q[JUMP_IDX_MSB:JUMP_IDX_LSB], 2'b00};

  // A stalled jump is not acted on; decode re-presents it once the stall
  // clears, so the redirect happens exactly once.
  assign jump_take = jumpId & valid_q & ~stall;

  // The branch is older than the instruction in ID, so it wins.
  assign redirect     = branchTaken | jump_take;
  assign redirect_tgt = branchTaken ? branchTarget : jump_tgt;

  fetch_skid_reg #(
    .Width(WIDTH)
  ) u_skid (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (skid_load),
    .clear_i    (skid_clear),
    .instr_i    (imemRdata),
    .pc_plus4_i (pc_plus4),
    .instr_o    (skid_instr),
    .pc_plus4_o (skid_pc4),
    .full_o     (skid_full)
  );

  // Fetch FSM and PC update.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        if (branchTaken) pc_d = branchTarget;
      end
      StFetch: begin
        if (redirect) begin
          if (imemReady) begin
            pc_d = redirect_tgt;
          end else begin
            // Address must not move under a pending request; park the target.
            redirect_pc_d = redirect_tgt;
            state_d       = StDiscard;
          end
        end else if (imemReady) begin
          pc_d = pc_plus4;
          if (stall) begin
            skid_load = 1'b1;
            state_d   = StHold;
          end
        end
      end
      StHold: begin
        if (redirect) begin
          skid_clear = 1'b1;
          pc_d       = redirect_tgt;
          state_d    = StFetch;
        end else if (!stall) begin
          skid_clear = 1'b1;
          state_d    = StFetch;
        end
      end
      StDiscard: begin
        if (redirect) redirect_pc_d = redirect_tgt;
        if (imemReady) begin
          pc_d    = redirect ? redirect_tgt : redirect_pc_q;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
    req_d = (state_d == StFetch) || (state_d == StDiscard);
  end

  // IF/ID register: flush beats stall, stall beats load.
  always_comb begin
    instr_d  = instr_q;
    pc4_id_d = pc4_id_q;
    valid_d  = valid_q;
    if (redirect) begin
      instr_d = WIDTH'(NOP);
      valid_d = 1'b0;
    end else if (!stall) begin
      if (state_q == StFetch && imemReady) begin
        instr_d  = imemRdata;
        pc4_id_d = pc_plus4;
        valid_d  = 1'b1;
      end else if (state_q == StHold && skid_full) begin
        instr_d  = skid_instr;
        pc4_id_d = skid_pc4;
        valid_d  = 1'b1;
      end else begin
        instr_d = WIDTH'(NOP);
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      redirect_pc_q <= RESET_PC;
      req_q         <= 1'b0;
      instr_q       <= '0;
      pc4_id_q      <= '0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      req_q         <= req_d;
      instr_q       <= instr_d;
      pc4_id_q      <= pc4_id_d;
      valid_q       <= valid_d;
    end
  end

  assign imemAddr  = pc_q;
  assign imemReq   = req_q;
  assign instrId   = instr_q;
  assign pcPlus4Id = pc4_id_q;
  assign validId   = valid_q;

endmodule
